// File: rtl/nios2_timer_mul_pkg.sv
// Shared types and constants for the two-pass 32x32 multiply sequencer
// built on the CPU's 16x16 partial-product cell.
package nios2_timer_mul_pkg;

   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      MUL    = 2'd0,
      MULXUU = 2'd1,
      MULXSS = 2'd2,
      MULXSU = 2'd3
   } mul_op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE_LO = 3'd1,
      ST_ISSUE_HI = 3'd2,
      ST_COLLECT  = 3'd3,
      ST_SUM      = 3'd4,
      ST_RESP     = 3'd5
   } mul_state_e;

   // Moves the upper half of a word into the low half so the cell's lo*lo product yields hi*hi.
   function automatic logic [WORD_W-1:0] hi_to_lo(input logic [WORD_W-1:0] w);
      return {{HALF_W{1'b0}}, w[WORD_W-1:HALF_W]};
   endfunction

endpackage

// File: rtl/nios2_timer_mul_combine.sv
// Combinational assembly of the four 16x16 partial products into the
// requested 32-bit result word, including signed high-word correction.
module nios2_timer_mul_combine
   import nios2_timer_mul_pkg::*;
#(
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic [WORD_W-1:0] ll_i,
   input  logic [WORD_W-1:0] lh_i,
   input  logic [WORD_W-1:0] hl_i,
   input  logic [WORD_W-1:0] hh_i,
   input  logic [WORD_W-1:0] a_i,
   input  logic [WORD_W-1:0] b_i,
   input  mul_op_e           op_i,
   output logic [WORD_W-1:0] result_o
);

   logic [WORD_W:0]     mid_sum_s;
   logic [2*WORD_W-1:0] prod_s;
   logic [WORD_W-1:0]   corr_a_s;
   logic [WORD_W-1:0]   corr_b_s;

   // Unsigned 64-bit product plus the two's-complement corrections for signed operands.
   always_comb begin
      mid_sum_s = {1'b0, lh_i} + {1'b0, hl_i};
      prod_s    = {{WORD_W{1'b0}}, ll_i}
                + {{(WORD_W-HALF_W-1){1'b0}}, mid_sum_s, {HALF_W{1'b0}}}
                + {hh_i, {WORD_W{1'b0}}};
      corr_a_s  = (SIGNED_EN && a_i[WORD_W-1]) ? b_i : {WORD_W{1'b0}};
      corr_b_s  = (SIGNED_EN && b_i[WORD_W-1]) ? a_i : {WORD_W{1'b0}};
      case (op_i)
         MUL:     result_o = prod_s[WORD_W-1:0];
         MULXUU:  result_o = prod_s[2*WORD_W-1:WORD_W];
         MULXSS:  result_o = prod_s[2*WORD_W-1:WORD_W] - corr_a_s - corr_b_s;
         MULXSU:  result_o = prod_s[2*WORD_W-1:WORD_W] - corr_a_s;
         default: result_o = prod_s[WORD_W-1:0];
      endcase
   end

endmodule

// File: rtl/nios2_timer_mul_sequencer.sv
// Sequencer that issues the 16x16 mult cell twice per 32x32 request and
// returns the selected 32-bit result word through a valid/ready response.
module nios2_timer_mul_sequencer
   import nios2_timer_mul_pkg::*;
#(
   parameter bit SIGNED_EN = 1'b1,
   parameter bit RESP_REG  = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [WORD_W-1:0] req_src1,
   input  logic [WORD_W-1:0] req_src2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_data,
   output logic [WORD_W-1:0] mc_src1,
   output logic [WORD_W-1:0] mc_src2,
   output logic              mc_en,
   input  logic [WORD_W-1:0] mc_p1,
   input  logic [WORD_W-1:0] mc_p2,
   input  logic [WORD_W-1:0] mc_p3
);

   generate
      if (RESP_REG != 1'b1) begin : g_resp_reg_unsupported
         $error("nios2_timer_mul_sequencer: RESP_REG=0 is reserved");
      end
   endgenerate

   mul_state_e        state_q;
   mul_op_e           op_q;
   logic [WORD_W-1:0] a_q;
   logic [WORD_W-1:0] b_q;
   logic [WORD_W-1:0] ll_q;
   logic [WORD_W-1:0] lh_q;
   logic [WORD_W-1:0] hl_q;
   logic [WORD_W-1:0] hh_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic [WORD_W-1:0] rsp_data_q;
   logic [WORD_W-1:0] mc_src1_q;
   logic [WORD_W-1:0] mc_src2_q;
   logic              mc_en_q;
   logic [WORD_W-1:0] rsp_data_d;

   nios2_timer_mul_combine #(
      .SIGNED_EN (SIGNED_EN)
   ) u_combine (
      .ll_i     (ll_q),
      .lh_i     (lh_q),
      .hl_i     (hl_q),
      .hh_i     (hh_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (rsp_data_d)
   );

   // Sequencer FSM; every output is a register loaded for the state being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         op_q        <= MUL;
         a_q         <= {WORD_W{1'b0}};
         b_q         <= {WORD_W{1'b0}};
         ll_q        <= {WORD_W{1'b0}};
         lh_q        <= {WORD_W{1'b0}};
         hl_q        <= {WORD_W{1'b0}};
         hh_q        <= {WORD_W{1'b0}};
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= {WORD_W{1'b0}};
         mc_src1_q   <= {WORD_W{1'b0}};
         mc_src2_q   <= {WORD_W{1'b0}};
         mc_en_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  op_q        <= mul_op_e'(req_op);
                  a_q         <= req_src1;
                  b_q         <= req_src2;
                  mc_src1_q   <= req_src1;
                  mc_src2_q   <= req_src2;
                  mc_en_q     <= 1'b1;
                  req_ready_q <= 1'b0;
                  state_q     <= ST_ISSUE_LO;
               end else begin
                  mc_en_q     <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            ST_ISSUE_LO: begin
               mc_src1_q <= hi_to_lo(a_q);
               mc_src2_q <= hi_to_lo(b_q);
               mc_en_q   <= 1'b1;
               state_q   <= ST_ISSUE_HI;
            end
            ST_ISSUE_HI: begin
               // Pass-1 products are visible now; pass 2 lands in the cell on this same edge.
               ll_q      <= mc_p1;
               lh_q      <= mc_p2;
               hl_q      <= mc_p3;
               mc_src1_q <= {WORD_W{1'b0}};
               mc_src2_q <= {WORD_W{1'b0}};
               mc_en_q   <= 1'b0;
               state_q   <= ST_COLLECT;
            end
            ST_COLLECT: begin
               hh_q    <= mc_p1;
               state_q <= ST_SUM;
            end
            ST_SUM: begin
               rsp_data_q  <= rsp_data_d;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end else begin
                  rsp_valid_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
               mc_en_q     <= 1'b0;
               mc_src1_q   <= {WORD_W{1'b0}};
               mc_src2_q   <= {WORD_W{1'b0}};
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign mc_src1   = mc_src1_q;
   assign mc_src2   = mc_src2_q;
   assign mc_en     = mc_en_q;

endmodule

// File: tb/tb_nios2_timer_mul_sequencer.sv
// Directed bench for the multiply sequencer with a behavioural 16x16 mult cell.
module tb_nios2_timer_mul_sequencer;
   import nios2_timer_mul_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [31:0] mc_src1;
   logic [31:0] mc_src2;
   logic        mc_en;
   logic [31:0] mc_p1;
   logic [31:0] mc_p2;
   logic [31:0] mc_p3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Mult cell: products registered on an enabled edge, held otherwise, cleared by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mc_p1 <= 32'h0;
         mc_p2 <= 32'h0;
         mc_p3 <= 32'h0;
      end else if (mc_en) begin
         mc_p1 <= {16'h0, mc_src1[15:0]}  * {16'h0, mc_src2[15:0]};
         mc_p2 <= {16'h0, mc_src1[15:0]}  * {16'h0, mc_src2[31:16]};
         mc_p3 <= {16'h0, mc_src1[31:16]} * {16'h0, mc_src2[15:0]};
      end
   end

   nios2_timer_mul_sequencer #(
      .SIGNED_EN (1'b1),
      .RESP_REG  (1'b1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_src1  (req_src1),
      .req_src2  (req_src2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .mc_src1   (mc_src1),
      .mc_src2   (mc_src2),
      .mc_en     (mc_en),
      .mc_p1     (mc_p1),
      .mc_p2     (mc_p2),
      .mc_p3     (mc_p3)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
      check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
      check({tag, "_rsp_data"},  rsp_data,           32'h0);
      check({tag, "_mc_en"},     {31'h0, mc_en},     32'h0);
      check({tag, "_mc_src1"},   mc_src1,            32'h0);
      check({tag, "_mc_src2"},   mc_src2,            32'h0);
   endtask

   // One full transaction; hold = number of extra cycles rsp_ready stays low in RESP.
   task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
      int cyc;
      int en_cnt;
      check({tag, "_accept_ready"}, {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1;
      req_op    = op;
      req_src1  = a;
      req_src2  = b;
      rsp_ready = (hold == 0);
      tick;
      req_valid = 1'b0;
      req_src1  = ~a;
      req_src2  = ~b;
      cyc    = 1;
      en_cnt = 0;
      while (rsp_valid !== 1'b1 && cyc < 20) begin
         if (mc_en === 1'b1) en_cnt++;
         tick;
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd5);
      check({tag, "_mc_en_cycles"}, 32'(en_cnt), 32'd2);
      check({tag, "_data"}, rsp_data, exp);
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1;
         req_op    = MULXSS;
         req_src1  = 32'hDEAD_BEEF;
         req_src2  = 32'h1357_9BDF;
         tick;
         check({tag, "_stall_ctl"}, {29'h0, rsp_valid, req_ready, mc_en}, 32'h4);
         check({tag, "_stall_data"}, rsp_data, exp);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick;
      check({tag, "_done_ctl"}, {30'h0, rsp_valid, req_ready}, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'd0;
      req_src1  = 32'h0;
      req_src2  = 32'h0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      reset_n = 1'b1;
      tick;

      do_op("mul_3x5",        MUL,    32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 0);
      do_op("mulxuu_ff",      MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      do_op("mul_ff",         MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      do_op("mulxss_ff",      MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0);
      do_op("mulxss_min",     MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
      do_op("mulxss_m2x3",    MULXSS, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 0);
      do_op("mulxsu_ff",      MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      do_op("mulxsu_2x8",     MULXSU, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001, 0);
      do_op("backpressure",   MUL,    32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 10);
      do_op("after_bp",       MULXUU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 0);

      // Reset asserted while the second pass is being issued.
      req_valid = 1'b1;
      req_op    = MUL;
      req_src1  = 32'h1234_5678;
      req_src2  = 32'h9ABC_DEF0;
      rsp_ready = 1'b1;
      tick;
      req_valid = 1'b0;
      tick;
      check("issue_hi_src1", mc_src1, 32'h0000_1234);
      check("issue_hi_src2", mc_src2, 32'h0000_9ABC);
      check("issue_hi_en",   {31'h0, mc_en}, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (rsp_valid !== 1'b0) seen++;
      end
      check("no_rsp_after_reset", 32'(seen), 32'd0);
      do_op("mul_7x9", MUL, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
